// File: rtl/bu2020_mem_responder.sv
// bu2020_mem_responder: memory-side responder for the BU2020 core.
// Serves a zero-latency instruction-fetch port and a data port that handles
// single-word and two-word (doubleRead/doubleWrite) transfers. The storage is
// a DEPTH x DATA_W array with combinational reads. A two-state FSM sequences
// the second word of a double transfer, and a sticky flag records protocol
// violations.
// Optional feature: define BU2020_MEM_PROTECT_EN to drop writes to addresses
// below PROTECT_LIMIT. A dropped write also raises proto_err.
module bu2020_mem_responder #(
    parameter int                 ADDR_W        = 12,
    parameter int                 DATA_W        = 16,
    parameter int                 DEPTH         = 4096,
    parameter logic [DATA_W-1:0]  NOP_WORD      = 16'hD000,
    parameter logic [ADDR_W-1:0]  PROTECT_LIMIT = 12'h100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Instruction_addressbus,
    output logic [DATA_W-1:0] Instruction_databus,
    input  logic [ADDR_W-1:0] Memory_addressbus,
    input  logic [DATA_W-1:0] Memory_incoming_data_bus,
    input  logic              Memory_writemode,
    input  logic              doubleRead,
    input  logic              doubleWrite,
    output logic [DATA_W-1:0] Memory_databus,
    output logic              mem_busy,
    output logic              proto_err
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  a2_reg;          // address of the second word
    logic               second_wr_reg;   // second word is a write
    logic               busy_reg;
    logic               err_reg;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               in_second;
    logic [ADDR_W-1:0]  data_addr;
    logic               wr_req;
    logic               wr_blocked;
    logic               wr_en;
    logic               err_set;

    assign in_second = (state_reg == SECOND);

    // While the second word is in progress, the latched address replaces the bus address.
    assign data_addr = in_second ? a2_reg : Memory_addressbus;

    // doubleWrite always writes. A doubleRead is a read whatever the writemode.
    assign wr_req = in_second ? second_wr_reg
                              : (doubleWrite | (Memory_writemode & ~doubleRead));

`ifdef BU2020_MEM_PROTECT_EN
    assign wr_blocked = wr_req && (data_addr < PROTECT_LIMIT);
`else
    logic unused_protect_limit;
    assign unused_protect_limit = ^PROTECT_LIMIT;
    assign wr_blocked = 1'b0;
`endif

    assign wr_en = wr_req & ~wr_blocked;

    // Violations: both double strobes together in IDLE, any double strobe during
    // SECOND (that request is dropped), or a write to a protected address.
    assign err_set = (~in_second & doubleRead & doubleWrite)
                   | (in_second & (doubleRead | doubleWrite))
                   | wr_blocked;

    // Both ports read combinationally, so a same-cycle write still shows the old word.
    // The outputs are forced to fixed values while reset is held.
    assign Instruction_databus = rst_n ? mem[Instruction_addressbus] : NOP_WORD;
    assign Memory_databus      = rst_n ? mem[data_addr] : '0;
    assign mem_busy            = busy_reg;
    assign proto_err           = err_reg;

    // Storage write port. The array is never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[data_addr] <= Memory_incoming_data_bus;
        end
    end

    // Transfer FSM with its registered busy flag and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a2_reg        <= '0;
            second_wr_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (err_set) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (doubleWrite || doubleRead) begin
                        state_reg     <= SECOND;
                        busy_reg      <= 1'b1;
                        a2_reg        <= Memory_addressbus + ADDR_W'(1);
                        second_wr_reg <= doubleWrite;
                    end
                end
                SECOND: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    second_wr_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bu2020_mem_responder.sv
// Testbench for bu2020_mem_responder: directed vectors, a transaction-level
// memory model checked every cycle, and literal expectations at key points.
module tb_bu2020_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] iaddr;
    logic [15:0] idata;
    logic [11:0] maddr;
    logic [15:0] wdata;
    logic        wm;
    logic        dr;
    logic        dw;
    logic [15:0] mdata;
    logic        busy;
    logic        perr;

    int n_checks = 0;
    int n_fail   = 0;

    bu2020_mem_responder dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .Instruction_addressbus   (iaddr),
        .Instruction_databus      (idata),
        .Memory_addressbus        (maddr),
        .Memory_incoming_data_bus (wdata),
        .Memory_writemode         (wm),
        .doubleRead               (dr),
        .doubleWrite              (dw),
        .Memory_databus           (mdata),
        .mem_busy                 (busy),
        .proto_err                (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: contents of written words, a pending second word, and the error flag.
    logic [15:0] m_mem   [4096];
    bit          m_known [4096];
    bit          m_pend;
    bit          m_pwr;
    logic [11:0] m_paddr;
    bit          m_err;

    function automatic void m_write(input logic [11:0] a, input logic [15:0] d);
`ifdef BU2020_MEM_PROTECT_EN
        if (a < 12'h100) begin
            m_err = 1'b1;
            return;
        end
`endif
        m_mem[a]   = d;
        m_known[a] = 1'b1;
    endfunction

    initial begin
        m_pend = 0; m_pwr = 0; m_paddr = '0; m_err = 0;
        for (int i = 0; i < 4096; i++) m_known[i] = 0;
    end

    // Model advances once per clock edge from the request seen in the finished cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend = 0;
            m_err  = 0;
        end else if (m_pend) begin
            if (m_pwr) m_write(m_paddr, wdata);
            if (dr || dw) m_err = 1;
            m_pend = 0;
        end else if (dw || dr) begin
            if (dw) m_write(maddr, wdata);
            if (dw && dr) m_err = 1;
            m_pwr   = dw;
            m_paddr = maddr + 12'd1;
            m_pend  = 1;
        end else if (wm) begin
            m_write(maddr, wdata);
        end
    end

    // Compare the DUT against the model in the middle of every cycle.
    always @(negedge clk) begin
        logic [11:0] a;
        if (!rst_n) begin
            chk("rst_instr", idata, 16'hD000);
            chk("rst_mdata", mdata, 16'h0000);
            chk("rst_busy", {15'd0, busy}, 16'd0);
            chk("rst_err", {15'd0, perr}, 16'd0);
        end else begin
            a = m_pend ? m_paddr : maddr;
            if (m_known[a])     chk("model_mdata", mdata, m_mem[a]);
            if (m_known[iaddr]) chk("model_instr", idata, m_mem[iaddr]);
            chk("model_busy", {15'd0, busy}, {15'd0, m_pend});
            chk("model_err", {15'd0, perr}, {15'd0, m_err});
        end
    end

    // Apply one cycle of inputs just after the edge, then stop mid-cycle for checks.
    task automatic cyc(input logic r, input logic w, input logic d_r, input logic d_w,
                       input logic [11:0] a, input logic [15:0] d, input logic [11:0] ia);
        @(posedge clk);
        #1;
        rst_n = r; wm = w; dr = d_r; dw = d_w; maddr = a; wdata = d; iaddr = ia;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; wm = 0; dr = 0; dw = 0; maddr = '0; wdata = '0; iaddr = '0;
        // Reset values
        cyc(0, 0, 0, 0, 12'h000, 16'h0000, 12'h000);
        cyc(0, 0, 0, 0, 12'h000, 16'h0000, 12'h000);
        chk("lit_reset_instr", idata, 16'hD000);
        chk("lit_reset_mdata", mdata, 16'h0000);
        chk("lit_reset_busy", {15'd0, busy}, 16'd0);

        // Single write, then overwrite: the write cycle shows the old word
        cyc(1, 1, 0, 0, 12'h200, 16'h1111, 12'h200);
        cyc(1, 1, 0, 0, 12'h200, 16'h1234, 12'h200);
        chk("lit_write_old_mdata", mdata, 16'h1111);
        chk("lit_write_old_instr", idata, 16'h1111);
        cyc(1, 0, 0, 0, 12'h200, 16'h0000, 12'h200);
        chk("lit_read_200", mdata, 16'h1234);

        // Double write at 300, then double read
        cyc(1, 1, 0, 1, 12'h300, 16'hAAAA, 12'h300);
        chk("lit_dw_busy1", {15'd0, busy}, 16'd0);
        cyc(1, 0, 0, 0, 12'h007, 16'h5555, 12'h301);
        chk("lit_dw_busy2", {15'd0, busy}, 16'd1);
        cyc(1, 0, 0, 0, 12'h300, 16'h0000, 12'h301);
        chk("lit_dw_busy3", {15'd0, busy}, 16'd0);
        chk("lit_mem_301", idata, 16'h5555);
        cyc(1, 0, 1, 0, 12'h300, 16'h0000, 12'h300);
        chk("lit_dr_word1", mdata, 16'hAAAA);
        chk("lit_dr_busy1", {15'd0, busy}, 16'd0);
        cyc(1, 0, 0, 0, 12'h123, 16'h0000, 12'h300);
        chk("lit_dr_word2", mdata, 16'h5555);
        chk("lit_dr_busy2", {15'd0, busy}, 16'd1);

        // Wrap at FFF
        cyc(1, 1, 0, 1, 12'hFFF, 16'h0001, 12'hFFF);
        cyc(1, 0, 0, 0, 12'h000, 16'h0002, 12'h000);
        cyc(1, 0, 0, 0, 12'hFFF, 16'h0000, 12'h000);
        chk("lit_wrap_fff", mdata, 16'h0001);
        chk("lit_wrap_000", idata, 16'h0002);
        chk("lit_no_err", {15'd0, perr}, 16'd0);

        // Reset during SECOND of a double write leaves the second word untouched
        cyc(1, 1, 0, 0, 12'h401, 16'h0077, 12'h401);
        cyc(1, 1, 0, 1, 12'h400, 16'h9999, 12'h401);
        cyc(0, 0, 0, 0, 12'h000, 16'h8888, 12'h401);
        chk("lit_abort_busy", {15'd0, busy}, 16'd0);
        cyc(1, 0, 0, 0, 12'h400, 16'h0000, 12'h401);
        chk("lit_abort_401", idata, 16'h0077);
        chk("lit_abort_400", mdata, 16'h9999);

        // doubleRead and doubleWrite together: handled as a double write, with an error
        cyc(1, 0, 1, 1, 12'h500, 16'hABCD, 12'h500);
        chk("lit_both_err_pre", {15'd0, perr}, 16'd0);
        cyc(1, 0, 0, 0, 12'h000, 16'hDCBA, 12'h501);
        chk("lit_both_err", {15'd0, perr}, 16'd1);
        cyc(1, 0, 0, 0, 12'h500, 16'h0000, 12'h501);
        chk("lit_both_w1", mdata, 16'hABCD);
        chk("lit_both_w2", idata, 16'hDCBA);

        // Reset clears the error; a new double request during SECOND sets it
        cyc(0, 0, 0, 0, 12'h000, 16'h0000, 12'h000);
        cyc(1, 0, 1, 0, 12'h600, 16'h0000, 12'h600);
        chk("lit_err_cleared", {15'd0, perr}, 16'd0);
        cyc(1, 0, 1, 0, 12'h700, 16'h0000, 12'h600);
        chk("lit_sec_busy", {15'd0, busy}, 16'd1);
        cyc(1, 0, 0, 0, 12'h700, 16'h0000, 12'h600);
        chk("lit_sec_err", {15'd0, perr}, 16'd1);
        chk("lit_sec_dropped", {15'd0, busy}, 16'd0);

        // Protection boundary
        cyc(0, 0, 0, 0, 12'h000, 16'h0000, 12'h000);
        cyc(1, 1, 0, 0, 12'h0FF, 16'hBEEF, 12'h0FF);
        cyc(1, 1, 0, 0, 12'h100, 16'hCAFE, 12'h0FF);
`ifdef BU2020_MEM_PROTECT_EN
        chk("lit_prot_err", {15'd0, perr}, 16'd1);
`else
        chk("lit_noprot_err", {15'd0, perr}, 16'd0);
        chk("lit_noprot_0ff", idata, 16'hBEEF);
`endif
        cyc(1, 0, 0, 0, 12'h100, 16'h0000, 12'h0FF);
        chk("lit_prot_100", mdata, 16'hCAFE);

        cyc(1, 0, 0, 0, 12'h000, 16'h0000, 12'h000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
